// File: rtl/motoro_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | motoro_pkg: shared state encoding, defaults and step-pattern decode  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package motoro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam int unsigned DEF_PER_MIN = 200;
  localparam int unsigned DEF_PER_MAX = 20000;
  localparam int unsigned DEF_DEAD    = 8;

  function automatic int unsigned step_w(input int unsigned phases);
    return $clog2(2 * phases);
  endfunction

  // High side of step s is phase s>>1.
  function automatic logic [7:0] hi_onehot(input logic [3:0] step);
    logic [7:0] v;
    v = '0;
    v[step[3:1]] = 1'b1;
    return v;
  endfunction

  // Low side is (h+1+(s&1)) mod phases; the sum never reaches 2*phases,
  // so one conditional subtract performs the modulo.
  function automatic logic [7:0] lo_onehot(input logic [3:0] step, input logic [3:0] phases);
    logic [3:0] l;
    logic [7:0] v;
    l = {1'b0, step[3:1]} + 4'd1 + {3'b000, step[0]};
    if (l >= phases) l = l - phases;
    v = '0;
    v[l[2:0]] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motoro_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | motoro_btn_edge: 2-flop synchroniser with rising-edge detector        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module motoro_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic [2:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], btn_i};
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule
`default_nettype wire

// File: rtl/motoro_nphase_commutator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | motoro_nphase_commutator: N-phase block commutator with dead time,   |
// | soft-start ramp and button-adjusted step period.  Rev 1.0             |
// +----------------------------------------------------------------------+
module motoro_nphase_commutator
  import motoro_pkg::*;
#(
  parameter int unsigned PHASES    = 3,
  parameter int unsigned PER_W     = 16,
  parameter int unsigned PER_MIN   = DEF_PER_MIN,
  parameter int unsigned PER_MAX   = DEF_PER_MAX,
  parameter int unsigned PER_STEP  = 100,
  parameter int unsigned RAMP_STEP = 50,
  parameter int unsigned DEAD      = DEF_DEAD,
  localparam int unsigned SW       = step_w(PHASES)
) (
  input  logic              clkI,
  input  logic              rstI,
  input  logic              startI,
  input  logic              forceStopI,
  input  logic              invRotateI,
  input  logic              freqINCi,
  input  logic              freqDECi,
  output logic [PHASES-1:0] hpO,
  output logic [PHASES-1:0] lnO,
  output logic [SW-1:0]     stepO,
  output logic              stepStbO,
  output logic              runO,
  output logic              faultO,
  output logic [PER_W-1:0]  periodO
);

  localparam logic [PER_W-1:0] C_PER_MIN = PER_W'(PER_MIN);
  localparam logic [PER_W-1:0] C_PER_MAX = PER_W'(PER_MAX);
  localparam logic [PER_W-1:0] C_STEP    = PER_W'(PER_STEP);
  localparam logic [PER_W-1:0] C_RAMP    = PER_W'(RAMP_STEP);
  localparam logic [PER_W-1:0] C_DEAD_M1 = PER_W'(DEAD - 1);
  localparam logic [PER_W-1:0] C_ONE     = PER_W'(1);
  localparam logic [PER_W-1:0] C_TGT_RST = PER_W'((PER_MAX / 2 / PER_STEP) * PER_STEP);
  localparam logic [SW-1:0]    C_LAST    = SW'(2 * PHASES - 1);
  localparam logic [3:0]       C_PHASES  = 4'(PHASES);

  state_e             state_q, state_d;
  logic [PER_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic [PER_W-1:0]   target_q, target_d;
  logic [SW-1:0]      s_q, s_d;
  logic               fault_q, fault_d;
  logic               stb_q, stb_d;
  logic [PHASES-1:0]  hp_q, hp_d;
  logic [PHASES-1:0]  ln_q, ln_d;
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;

  logic w_start, w_force, w_inv, w_inc, w_dec;
  logic [3:0]        w_s_ext;
  logic [7:0]        w_hi8, w_lo8;
  logic [SW-1:0]     w_s_next;
  logic [PER_W-1:0]  w_period_ramp;

  motoro_btn_edge u_inc (.clk(clkI), .rst(rstI), .btn_i(freqINCi), .rise_o(w_inc));
  motoro_btn_edge u_dec (.clk(clkI), .rst(rstI), .btn_i(freqDECi), .rise_o(w_dec));

  always_comb begin
    sync1_d = {startI, forceStopI, invRotateI};
    sync2_d = sync1_q;
  end

  assign w_start = sync2_q[2];
  assign w_force = sync2_q[1];
  assign w_inv   = sync2_q[0];

  always_comb begin
    w_s_ext = '0;
    w_s_ext[SW-1:0] = s_q;
    w_hi8 = hi_onehot(w_s_ext);
    w_lo8 = lo_onehot(w_s_ext, C_PHASES);
  end

  always_comb begin
    if (w_inv) w_s_next = (s_q == '0) ? C_LAST : s_q - 1'b1;
    else       w_s_next = (s_q == C_LAST) ? '0 : s_q + 1'b1;
    if (period_q > target_q && (period_q - target_q) > C_RAMP) w_period_ramp = period_q - C_RAMP;
    else                                                       w_period_ramp = target_q;
  end

  // Target tracks the buttons in every state; simultaneous presses cancel.
  always_comb begin
    target_d = target_q;
    if (w_inc && !w_dec)
      target_d = (target_q >= C_PER_MIN + C_STEP) ? target_q - C_STEP : C_PER_MIN;
    else if (w_dec && !w_inc)
      target_d = (target_q <= C_PER_MAX - C_STEP) ? target_q + C_STEP : C_PER_MAX;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    period_d = period_q;
    fault_d  = fault_q;
    stb_d    = 1'b0;
    hp_d     = '0;
    ln_d     = '1;
    case (state_q)
      ST_IDLE: begin
        if (w_start && !fault_q) begin
          state_d  = ST_DEAD;
          cnt_d    = '0;
          s_d      = '0;
          period_d = C_PER_MAX;
        end
      end
      ST_DEAD: begin
        if (cnt_q == C_DEAD_M1) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          stb_d   = 1'b1;
          hp_d    = w_hi8[PHASES-1:0];
          ln_d    = ~w_lo8[PHASES-1:0];
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == period_q - C_ONE) begin
          state_d  = ST_DEAD;
          cnt_d    = '0;
          s_d      = w_s_next;
          period_d = w_period_ramp;
        end else begin
          cnt_d = cnt_q + C_ONE;
          hp_d  = w_hi8[PHASES-1:0];
          ln_d  = ~w_lo8[PHASES-1:0];
        end
      end
      ST_FAULT: begin
        if (!w_start && !w_force) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q == ST_DEAD || state_q == ST_DRIVE) && !w_start) begin
      state_d = ST_IDLE;
      stb_d   = 1'b0;
      hp_d    = '0;
      ln_d    = '1;
    end
    // Emergency stop overrides everything, including a pending start.
    if (w_force && state_q != ST_FAULT) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
      stb_d   = 1'b0;
      hp_d    = '0;
      ln_d    = '1;
    end
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      s_q      <= '0;
      period_q <= C_PER_MAX;
      target_q <= C_TGT_RST;
      fault_q  <= 1'b0;
      stb_q    <= 1'b0;
      hp_q     <= '0;
      ln_q     <= '1;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      period_q <= period_d;
      target_q <= target_d;
      fault_q  <= fault_d;
      stb_q    <= stb_d;
      hp_q     <= hp_d;
      ln_q     <= ln_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
    end
  end

  assign hpO      = hp_q;
  assign lnO      = ln_q;
  assign stepO    = s_q;
  assign stepStbO = stb_q;
  assign runO     = (state_q == ST_DEAD) || (state_q == ST_DRIVE);
  assign faultO   = fault_q;
  assign periodO  = period_q;

endmodule
`default_nettype wire

// File: tb/tb_motoro_nphase_commutator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_motoro_nphase_commutator: directed self-checking bench, 3 phases  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_motoro_nphase_commutator;

  logic       clk = 1'b0;
  logic       rstI, startI, forceStopI, invRotateI, freqINCi, freqDECi;
  logic [2:0] hpO, lnO, stepO;
  logic       stepStbO, runO, faultO;
  logic [15:0] periodO;

  int errors = 0;
  int checks = 0;

  logic [2:0] hp_tab [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
  logic [2:0] ln_tab [6] = '{3'b101, 3'b011, 3'b011, 3'b110, 3'b110, 3'b101};

  motoro_nphase_commutator #(
    .PHASES(3), .PER_W(16), .PER_MIN(20), .PER_MAX(100),
    .PER_STEP(10), .RAMP_STEP(20), .DEAD(4)
  ) dut (
    .clkI(clk), .rstI(rstI), .startI(startI), .forceStopI(forceStopI),
    .invRotateI(invRotateI), .freqINCi(freqINCi), .freqDECi(freqDECi),
    .hpO(hpO), .lnO(lnO), .stepO(stepO), .stepStbO(stepStbO),
    .runO(runO), .faultO(faultO), .periodO(periodO)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits for the next step strobe, counting fully-off cycles on the way.
  task automatic wait_stb(output int offc);
    int n;
    offc = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (hpO == 3'b000 && lnO == 3'b111) offc++;
    end while (!stepStbO && n < 400);
    if (!stepStbO) begin
      checks++; errors++;
      $display("FAIL stb_timeout: no stepStbO after %0d cycles", n);
    end
  endtask

  task automatic pulse_btn(input logic inc, input logic dec);
    freqINCi = inc; freqDECi = dec;
    cyc(2);
    freqINCi = 1'b0; freqDECi = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset;
    rstI = 1'b1; startI = 1'b0; forceStopI = 1'b0; invRotateI = 1'b0;
    freqINCi = 1'b0; freqDECi = 1'b0;
    cyc(3);
    checks++;
    if ({hpO, lnO, stepO, stepStbO, runO, faultO} !== {3'b000, 3'b111, 3'b000, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got hp=%b ln=%b step=%0d stb=%b run=%b fault=%b expected 000/111/0/0/0/0",
               hpO, lnO, stepO, stepStbO, runO, faultO);
    end
    checks++;
    if (periodO !== 16'd100) begin
      errors++; $display("FAIL reset_period: got %0d expected 100", periodO);
    end
    rstI = 1'b0;
    cyc(2);
  endtask

  task automatic test_start_ramp;
    int offc;
    int per_exp [6] = '{80, 60, 50, 50, 50, 50};
    startI = 1'b1;
    cyc(2);
    checks++;
    if (runO !== 1'b0) begin errors++; $display("FAIL start_latency_run: got %b expected 0", runO); end
    cyc(1);
    checks++;
    if (runO !== 1'b1) begin errors++; $display("FAIL start_run: got %b expected 1", runO); end
    cyc(3);
    checks++;
    if (hpO !== 3'b000 || lnO !== 3'b111) begin
      errors++; $display("FAIL start_dead: got hp=%b ln=%b expected 000/111", hpO, lnO);
    end
    cyc(1);
    checks++;
    if ({hpO, lnO, stepO, stepStbO} !== {3'b001, 3'b101, 3'd0, 1'b1} || periodO !== 16'd100) begin
      errors++;
      $display("FAIL first_step: got hp=%b ln=%b step=%0d stb=%b per=%0d expected 001/101/0/1/100",
               hpO, lnO, stepO, stepStbO, periodO);
    end
    for (int k = 1; k <= 6; k++) begin
      wait_stb(offc);
      checks++;
      if (stepO !== 3'(k % 6) || hpO !== hp_tab[k % 6] || lnO !== ln_tab[k % 6] ||
          periodO !== 16'(per_exp[k-1]) || offc != 4) begin
        errors++;
        $display("FAIL fwd_step%0d: got step=%0d hp=%b ln=%b per=%0d off=%0d expected %0d/%b/%b/%0d/4",
                 k, stepO, hpO, lnO, periodO, offc, k % 6, hp_tab[k % 6], ln_tab[k % 6], per_exp[k-1]);
      end
    end
  endtask

  task automatic test_reverse;
    int offc;
    int seq [5] = '{3, 2, 1, 0, 5};
    for (int k = 0; k < 6 && stepO != 3'd4; k++) wait_stb(offc);
    cyc(5);
    invRotateI = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_stb(offc);
      checks++;
      if (stepO !== 3'(seq[k]) || hpO !== hp_tab[seq[k]] || lnO !== ln_tab[seq[k]] || offc != 4) begin
        errors++;
        $display("FAIL rev_step%0d: got step=%0d hp=%b ln=%b off=%0d expected %0d/%b/%b/4",
                 k, stepO, hpO, lnO, offc, seq[k], hp_tab[seq[k]], ln_tab[seq[k]]);
      end
    end
    invRotateI = 1'b0;
  endtask

  task automatic test_target;
    int offc;
    for (int k = 0; k < 5; k++) pulse_btn(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) wait_stb(offc);
    checks++;
    if (periodO !== 16'd20) begin errors++; $display("FAIL inc_saturate: got %0d expected 20", periodO); end
    pulse_btn(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) wait_stb(offc);
    checks++;
    if (periodO !== 16'd20) begin errors++; $display("FAIL both_at_min: got %0d expected 20", periodO); end
    for (int k = 0; k < 10; k++) pulse_btn(1'b0, 1'b1);
    for (int k = 0; k < 2; k++) wait_stb(offc);
    checks++;
    if (periodO !== 16'd100) begin errors++; $display("FAIL dec_saturate: got %0d expected 100", periodO); end
    pulse_btn(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) wait_stb(offc);
    checks++;
    if (periodO !== 16'd100) begin errors++; $display("FAIL both_at_max: got %0d expected 100", periodO); end
  endtask

  task automatic test_force_stop;
    int offc;
    wait_stb(offc);
    forceStopI = 1'b1;
    cyc(2);
    checks++;
    if (hpO === 3'b000 || faultO !== 1'b0) begin
      errors++; $display("FAIL force_latency: got hp=%b fault=%b expected driving/0", hpO, faultO);
    end
    cyc(1);
    checks++;
    if ({hpO, lnO, faultO, runO} !== {3'b000, 3'b111, 1'b1, 1'b0}) begin
      errors++; $display("FAIL force_off: got hp=%b ln=%b fault=%b run=%b expected 000/111/1/0",
                         hpO, lnO, faultO, runO);
    end
    forceStopI = 1'b0;
    cyc(10);
    checks++;
    if (faultO !== 1'b1 || runO !== 1'b0 || hpO !== 3'b000) begin
      errors++; $display("FAIL fault_hold: got fault=%b run=%b hp=%b expected 1/0/000", faultO, runO, hpO);
    end
    startI = 1'b0;
    cyc(3);
    checks++;
    if (faultO !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", faultO); end
    startI = 1'b1;
    wait_stb(offc);
    checks++;
    if (stepO !== 3'd0 || periodO !== 16'd100) begin
      errors++; $display("FAIL restart: got step=%0d per=%0d expected 0/100", stepO, periodO);
    end
  endtask

  task automatic test_reset_and_stop;
    int offc, n, stbs;
    wait_stb(offc);
    cyc(3);
    rstI = 1'b1;
    cyc(1);
    checks++;
    if ({hpO, lnO, runO} !== {3'b000, 3'b111, 1'b0} || periodO !== 16'd100) begin
      errors++; $display("FAIL reset_mid_drive: got hp=%b ln=%b run=%b per=%0d expected 000/111/0/100",
                         hpO, lnO, runO, periodO);
    end
    rstI = 1'b0;
    wait_stb(offc);
    n = 0;
    while (hpO != 3'b000 && n < 300) begin @(negedge clk); n++; end
    startI = 1'b0;
    cyc(3);
    checks++;
    if (runO !== 1'b0 || hpO !== 3'b000) begin
      errors++; $display("FAIL stop_mid_dead: got run=%b hp=%b expected 0/000", runO, hpO);
    end
    stbs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stepStbO || hpO != 3'b000) stbs++;
    end
    checks++;
    if (stbs != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", stbs); end
  endtask

  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      startI     = ($urandom_range(0, 19) != 0);
      forceStopI = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) invRotateI = ~invRotateI;
      freqINCi   = ($urandom_range(0, 7) == 0);
      freqDECi   = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      checks++;
      if ((hpO & ~lnO) !== 3'b000) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL shoot_through: got hp=%b ln=%b expected no overlap", hpO, lnO);
      end
    end
    startI = 1'b0; forceStopI = 1'b0; freqINCi = 1'b0; freqDECi = 1'b0;
  endtask

  initial begin
    test_reset;
    test_start_ramp;
    test_reverse;
    test_target;
    test_force_stop;
    test_reset_and_stop;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
